mult_div_unit: RTL and testbench

Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair. It sits directly downstream of the register file and consumes its two read-data outputs (rs, rt). It raises busy so control can stall dependent instructions, and drives hi/lo back toward the writeback mux for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
// Each operation takes WIDTH step cycles: shift-add for multiply, restoring shift-subtract for divide.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             is_div_q,  is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q,    div0_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [PW-1:0]    acc_q,     acc_d;

    // Operand magnitudes; only signed ops take the absolute value.
    logic             is_signed_c;
    logic [WIDTH-1:0] abs_rs_c, abs_rt_c;

    always_comb begin
        is_signed_c = ~op[0];
        abs_rs_c    = (is_signed_c & rs_data[WIDTH-1]) ? (~rs_data + WIDTH'(1)) : rs_data;
        abs_rt_c    = (is_signed_c & rt_data[WIDTH-1]) ? (~rt_data + WIDTH'(1)) : rt_data;
    end

    // One iteration: acc holds {upper, lower}; multiply shifts right, divide shifts left.
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   rem_sh_c, rem_diff_c;
    logic [PW-1:0]    mul_next_c, div_next_c, step_c;
    logic [PW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_c, rem_c, quo_fix_c, rem_fix_c;

    always_comb begin
        mul_sum_c  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

        rem_sh_c   = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff_c = rem_sh_c - {1'b0, b_q};
        div_next_c = rem_diff_c[WIDTH] ? {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {rem_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        step_c     = is_div_q ? div_next_c : mul_next_c;

        prod_fix_c = neg_res_q ? (~step_c + PW'(1)) : step_c;
        quo_c      = step_c[WIDTH-1:0];
        rem_c      = step_c[PW-1:WIDTH];
        // Divide by zero leaves |rs| in the remainder, so re-signing it restores rs.
        quo_fix_c  = div0_q ? '1 : (neg_res_q ? (~quo_c + WIDTH'(1)) : quo_c);
        rem_fix_c  = neg_rem_q ? (~rem_c + WIDTH'(1)) : rem_c;
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        b_d       = b_q;
        acc_d     = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    neg_res_d = is_signed_c & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    neg_rem_d = is_signed_c & op[1] & rs_data[WIDTH-1];
                    div0_d    = op[1] & (rt_data == '0);
                    b_d       = abs_rt_c;
                    acc_d     = {{WIDTH{1'b0}}, abs_rs_c};
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            S_RUN: begin
                acc_d = step_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix_c;
                        lo_d = quo_fix_c;
                    end else begin
                        hi_d = prod_fix_c[PW-1:WIDTH];
                        lo_d = prod_fix_c[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, done pulse, mthi/mtlo and reset abort.
module tb_mult_div_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data, rt_data, wr_data;
    logic             mthi, mtlo;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch at a negedge, scramble operands during RUN, wait for done with a bound.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int j;
        int nb;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1357_9BDF;
        j  = 0;
        nb = 0;
        while (!done && j < 40) begin
            if (busy) nb++;
            @(negedge clk);
            j++;
        end
        check({tag, " latency"}, 64'(j), 64'd32);
        check({tag, " busy cycles"}, 64'(nb), 64'd32);
        check({tag, " busy low"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, " done one-shot"}, 64'(done), 64'd0);
    endtask

    initial begin
        int j;
        int seen;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op("multu max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult -3x7",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("mult min^2",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        do_op("div -7/2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu 100/7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
        do_op("div ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        do_op("divu by 0",   2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
        do_op("div -100/0",  2'b10, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF);
        do_op("div 7/-2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);

        // start and mthi while busy are both ignored
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd6;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        seen = 0;
        while (!done && j < 40) begin
            if (j == 10) begin start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; end
            if (j == 11) start = 1'b0;
            if (j == 12) begin mthi = 1'b1; wr_data = 32'hAAAA_AAAA; end
            if (j == 13) mthi = 1'b0;
            @(negedge clk);
            j++;
        end
        check("busy-ignore latency", 64'(j), 64'd32);
        check("busy-ignore hi", 64'(hi), 64'd0);
        check("busy-ignore lo", 64'(lo), 64'd30);
        @(negedge clk);
        check("busy-ignore still idle", 64'(busy), 64'd0);

        mtlo = 1'b1; wr_data = 32'h0000_1234;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo lo", 64'(lo), 64'h1234);
        check("mtlo hi kept", 64'(hi), 64'd0);
        mthi = 1'b1; wr_data = 32'h0000_0055;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'h55);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0000_0077;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h77);
        check("mthi+mtlo lo", 64'(lo), 64'h77);

        // start wins over mthi in the same idle cycle
        mthi = 1'b1; wr_data = 32'h0000_9999;
        start = 1'b1; op = 2'b01; rs_data = 32'd2; rt_data = 32'd3;
        @(negedge clk);
        mthi = 1'b0; start = 1'b0;
        check("start-wins busy", 64'(busy), 64'd1);
        check("start-wins hi held", 64'(hi), 64'h77);
        j = 0;
        while (!done && j < 40) begin @(negedge clk); j++; end
        check("start-wins latency", 64'(j), 64'd32);
        check("start-wins hi", 64'(hi), 64'd0);
        check("start-wins lo", 64'(lo), 64'd6);
        @(negedge clk);

        // reset mid-operation aborts with no done pulse
        start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        check("abort no activity", 64'(seen), 64'd0);
        do_op("after reset", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
